// File: rtl/dram_req_scheduler.sv
// DRAM request scheduler: FIFO buffering, credit-limited valid/ready issue, back-pressure, enable/drain FSM.
// Optional macro DRAM_SCHED_PERF_EN adds saturating performance counters.
module dram_req_scheduler #(
    parameter int DEPTH   = 8,
    parameter int MAX_OUT = 16,
    parameter int TAG_W   = 10
) (
    input  logic                       Clk_32UI,
    input  logic                       reset_n,
    input  logic                       sched_en,
    input  logic                       req_valid,
    input  logic [31:0]                req_addr_k,
    input  logic [31:0]                req_addr_l,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       bp_stall,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_addr_k,
    output logic [31:0]                mem_addr_l,
    output logic [TAG_W-1:0]           mem_req_tag,
    input  logic                       mem_resp_valid,
    output logic [7:0]                 outstanding,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       drained,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic [1:0]                 sched_state
`ifdef DRAM_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_issued,
    output logic [31:0]                perf_bp_cycles,
    output logic [31:0]                perf_credit_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TAG_W + 64;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    // Handshake: a request transfers on any cycle where mem_req_valid && mem_req_ready;
    // valid depends only on registered state, so it never drops before acceptance.
    state_t          state, state_next;
    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_next;
    logic [EW-1:0]   head, hold;
    logic [7:0]      out_next;
    logic            full, empty, push, pop, overflow, underflow, drained_next;

    assign full     = (fifo_count == CW'(DEPTH));
    assign empty    = (fifo_count == '0);
    assign pop      = mem_req_valid && mem_req_ready;
    assign push     = req_valid && (!full || pop);
    assign overflow = req_valid && full && !pop;
    assign head     = fifo_mem[rd_ptr];
    assign sched_state = state;

    assign mem_req_valid = ((state == RUN) || (state == DRAIN)) && !empty &&
                           (outstanding < 8'(MAX_OUT));
    // An empty FIFO shows the most recently issued entry instead of a stale slot.
    assign {mem_req_tag, mem_addr_l, mem_addr_k} = empty ? hold : head;

    always_ff @(posedge Clk_32UI) begin
        if (push) fifo_mem[wr_ptr] <= {req_tag, req_addr_l, req_addr_k};
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop)      count_next = fifo_count + CW'(1);
        else if (!push && pop) count_next = fifo_count - CW'(1);
    end

    always_comb begin
        out_next  = outstanding;
        underflow = 1'b0;
        case ({pop, mem_resp_valid})
            2'b10:   out_next = outstanding + 8'd1;
            2'b01: begin
                if (outstanding == 8'd0) underflow = 1'b1;
                else                     out_next  = outstanding - 8'd1;
            end
            default: out_next = outstanding;
        endcase
    end

    always_comb begin
        state_next   = state;
        drained_next = 1'b0;
        unique case (state)
            IDLE:    if (sched_en) state_next = RUN;
            RUN:     if (!sched_en) state_next = DRAIN;
            DRAIN: begin
                if (sched_en) begin
                    state_next = RUN;
                end else if ((count_next == '0) && (out_next == 8'd0)) begin
                    state_next   = IDLE;
                    drained_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            hold          <= '0;
            outstanding   <= '0;
            bp_stall      <= 1'b0;
            drained       <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state       <= state_next;
            fifo_count  <= count_next;
            outstanding <= out_next;
            drained     <= drained_next;
            bp_stall    <= (count_next >= CW'(DEPTH - 2));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= head;
            end
            if (overflow)  err_overflow  <= 1'b1;
            if (underflow) err_underflow <= 1'b1;
        end
    end

`ifdef DRAM_SCHED_PERF_EN
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued        <= '0;
            perf_bp_cycles     <= '0;
            perf_credit_cycles <= '0;
        end else if (state != IDLE) begin
            if (pop && (perf_issued != '1))
                perf_issued <= perf_issued + 32'd1;
            if (bp_stall && (perf_bp_cycles != '1))
                perf_bp_cycles <= perf_bp_cycles + 32'd1;
            if (!empty && (outstanding == 8'(MAX_OUT)) && (perf_credit_cycles != '1))
                perf_credit_cycles <= perf_credit_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_req_scheduler.sv
// Bench for dram_req_scheduler: hand vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_dram_req_scheduler;

    localparam int DEPTH   = 8;
    localparam int MAX_OUT = 16;
    localparam int TAG_W   = 10;
    localparam int EW      = TAG_W + 64;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic             Clk_32UI = 1'b0;
    logic             reset_n  = 1'b0;
    logic             sched_en = 1'b0;
    logic             req_valid = 1'b0;
    logic [31:0]      req_addr_k = '0;
    logic [31:0]      req_addr_l = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             mem_req_ready = 1'b0;
    logic             mem_resp_valid = 1'b0;
    logic             bp_stall, mem_req_valid, drained, err_overflow, err_underflow;
    logic [31:0]      mem_addr_k, mem_addr_l;
    logic [TAG_W-1:0] mem_req_tag;
    logic [7:0]       outstanding;
    logic [3:0]       fifo_count;
    logic [1:0]       sched_state;

    dram_req_scheduler #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .TAG_W(TAG_W)) dut (
        .Clk_32UI(Clk_32UI), .reset_n(reset_n), .sched_en(sched_en),
        .req_valid(req_valid), .req_addr_k(req_addr_k), .req_addr_l(req_addr_l),
        .req_tag(req_tag), .bp_stall(bp_stall), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr_k(mem_addr_k), .mem_addr_l(mem_addr_l),
        .mem_req_tag(mem_req_tag), .mem_resp_valid(mem_resp_valid),
        .outstanding(outstanding), .fifo_count(fifo_count), .drained(drained),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .sched_state(sched_state)
    );

    always #5 Clk_32UI = ~Clk_32UI;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: expected FIFO contents plus plain counters and flags.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] m_last;
    int            m_out, m_state;
    bit            m_bp, m_ovf, m_unf, m_drained;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = '0; m_out = 0; m_state = M_IDLE;
        m_bp = 0; m_ovf = 0; m_unf = 0; m_drained = 0;
    endtask

    task automatic model_step();
        bit mvalid, issue;
        mvalid = (m_state != M_IDLE) && (exp_q.size() > 0) && (m_out < MAX_OUT);
        issue  = mvalid && mem_req_ready;
        if (issue) begin
            m_last = exp_q.pop_front();
        end
        if (req_valid) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({req_tag, req_addr_l, req_addr_k});
            else                      m_ovf = 1;
        end
        if (issue && !mem_resp_valid) m_out++;
        else if (!issue && mem_resp_valid) begin
            if (m_out == 0) m_unf = 1;
            else            m_out--;
        end
        m_bp = (exp_q.size() >= DEPTH - 2);
        m_drained = 0;
        case (m_state)
            M_IDLE:  if (sched_en) m_state = M_RUN;
            M_RUN:   if (!sched_en) m_state = M_DRAIN;
            default: begin
                if (sched_en) m_state = M_RUN;
                else if (exp_q.size() == 0 && m_out == 0) begin
                    m_state = M_IDLE;
                    m_drained = 1;
                end
            end
        endcase
    endtask

    task automatic check_all();
        logic [EW-1:0] e_head;
        bit mvalid;
        mvalid = (m_state != M_IDLE) && (exp_q.size() > 0) && (m_out < MAX_OUT);
        e_head = (exp_q.size() > 0) ? exp_q[0] : m_last;
        chk("mem_req_valid", 64'(mem_req_valid), 64'(mvalid));
        chk("mem_addr_k", 64'(mem_addr_k), 64'(e_head[31:0]));
        chk("mem_addr_l", 64'(mem_addr_l), 64'(e_head[63:32]));
        chk("mem_req_tag", 64'(mem_req_tag), 64'(e_head[EW-1:64]));
        chk("outstanding", 64'(outstanding), 64'(m_out));
        chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
        chk("bp_stall", 64'(bp_stall), 64'(m_bp));
        chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
        chk("err_underflow", 64'(err_underflow), 64'(m_unf));
        chk("drained", 64'(drained), 64'(m_drained));
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk_32UI);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        sched_en = 0; req_valid = 0; req_addr_k = '0; req_addr_l = '0;
        req_tag = '0; mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    task automatic set_req(input logic v, input logic [31:0] k, input logic [31:0] l,
                           input logic [TAG_W-1:0] t);
        req_valid = v; req_addr_k = k; req_addr_l = l; req_tag = t;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        clear_inputs();
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        chk("reset_valid", 64'(mem_req_valid), 64'd0);
        @(posedge Clk_32UI);
        @(posedge Clk_32UI);
        #1;
        reset_n = 1;
    endtask

    typedef struct {
        logic en, rv;
        logic [31:0] k, l;
        logic [TAG_W-1:0] tag;
        logic rdy, rsp;
        logic e_valid;
        logic [31:0] e_k;
        logic [TAG_W-1:0] e_tag;
        logic [7:0] e_out;
        logic [3:0] e_cnt;
        logic e_bp, e_ovf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        model_reset();
        // single request round trip, then fill to overflow with ready low
        tbl[0]  = '{1, 0, 32'h0,    32'h0,    10'd0, 0, 0, 0, 32'h0,    10'd0, 8'd0, 4'd0, 0, 0};
        tbl[1]  = '{1, 1, 32'h100,  32'h200,  10'd5, 1, 0, 1, 32'h100,  10'd5, 8'd0, 4'd1, 0, 0};
        tbl[2]  = '{1, 0, 32'h0,    32'h0,    10'd0, 1, 0, 0, 32'h100,  10'd5, 8'd1, 4'd0, 0, 0};
        tbl[3]  = '{1, 0, 32'h0,    32'h0,    10'd0, 0, 1, 0, 32'h100,  10'd5, 8'd0, 4'd0, 0, 0};
        for (int i = 1; i <= 9; i++) begin
            tbl[3+i] = '{1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 10'(i), 0, 0,
                         1, 32'h1001, 10'd1, 8'd0, 4'((i > 8) ? 8 : i),
                         (i >= 6), (i == 9)};
        end

        do_reset();
        for (int i = 0; i < 13; i++) begin
            sched_en = tbl[i].en;
            set_req(tbl[i].rv, tbl[i].k, tbl[i].l, tbl[i].tag);
            mem_req_ready = tbl[i].rdy;
            mem_resp_valid = tbl[i].rsp;
            cycle();
            chk($sformatf("tbl%0d_valid", i), 64'(mem_req_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_k", i), 64'(mem_addr_k), 64'(tbl[i].e_k));
            chk($sformatf("tbl%0d_tag", i), 64'(mem_req_tag), 64'(tbl[i].e_tag));
            chk($sformatf("tbl%0d_out", i), 64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("tbl%0d_cnt", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_bp", i), 64'(bp_stall), 64'(tbl[i].e_bp));
            chk($sformatf("tbl%0d_ovf", i), 64'(err_overflow), 64'(tbl[i].e_ovf));
        end

        // credit limit: 20 pushes with no responses
        do_reset();
        sched_en = 1; cycle();
        mem_req_ready = 1;
        for (int i = 0; i < 20; i++) begin
            set_req(1, 32'h3000 + 32'(i), 32'h4000 + 32'(i), 10'(100 + i));
            cycle();
        end
        set_req(0, '0, '0, '0);
        repeat (5) cycle();
        chk("credit_out", 64'(outstanding), 64'd16);
        chk("credit_valid", 64'(mem_req_valid), 64'd0);
        chk("credit_cnt", 64'(fifo_count), 64'd4);
        mem_resp_valid = 1; cycle();
        mem_resp_valid = 0; cycle();
        chk("credit_reissue_out", 64'(outstanding), 64'd16);
        chk("credit_reissue_cnt", 64'(fifo_count), 64'd3);

        // same-cycle issue and response, then underflow
        do_reset();
        sched_en = 1; cycle();
        mem_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 32'h50 + 32'(i), 32'h60, 10'(i)); cycle();
        end
        set_req(0, '0, '0, '0);
        repeat (2) cycle();
        chk("same_pre_out", 64'(outstanding), 64'd3);
        set_req(1, 32'h77, 32'h88, 10'd9); cycle();
        set_req(0, '0, '0, '0);
        mem_resp_valid = 1; cycle();
        chk("same_cycle_out", 64'(outstanding), 64'd3);
        repeat (3) cycle();
        chk("resp_out_zero", 64'(outstanding), 64'd0);
        chk("no_unf_yet", 64'(err_underflow), 64'd0);
        cycle();
        mem_resp_valid = 0;
        chk("underflow_flag", 64'(err_underflow), 64'd1);
        chk("underflow_out", 64'(outstanding), 64'd0);

        // drain with 4 queued and 2 outstanding
        do_reset();
        sched_en = 1; cycle();
        mem_req_ready = 1;
        for (int i = 0; i < 2; i++) begin
            set_req(1, 32'h900 + 32'(i), 32'h0, 10'(i)); cycle();
        end
        set_req(0, '0, '0, '0);
        repeat (2) cycle();
        mem_req_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 32'h910 + 32'(i), 32'h1, 10'(i + 2)); cycle();
        end
        set_req(0, '0, '0, '0);
        sched_en = 0; mem_req_ready = 1;
        repeat (4) cycle();
        chk("drain_issued_out", 64'(outstanding), 64'd6);
        chk("drain_issued_cnt", 64'(fifo_count), 64'd0);
        mem_resp_valid = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("drain_early_pulse", 64'(drained), 64'd0);
        end
        cycle();
        chk("drained_pulse", 64'(drained), 64'd1);
        mem_resp_valid = 0; cycle();
        chk("drained_one_cycle", 64'(drained), 64'd0);
        set_req(1, 32'hABC, 32'hDEF, 10'd3); cycle();
        set_req(0, '0, '0, '0);
        repeat (2) cycle();
        chk("idle_no_issue", 64'(mem_req_valid), 64'd0);
        chk("idle_queued", 64'(fifo_count), 64'd1);

        // asynchronous reset mid-burst, then late response and fresh issue
        do_reset();
        sched_en = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 32'h700 + 32'(i), 32'h800, 10'(i)); cycle();
        end
        set_req(0, '0, '0, '0);
        chk("burst_valid", 64'(mem_req_valid), 64'd1);
        do_reset();
        chk("post_reset_cnt", 64'(fifo_count), 64'd0);
        mem_resp_valid = 1; cycle();
        mem_resp_valid = 0;
        chk("late_resp_unf", 64'(err_underflow), 64'd1);
        sched_en = 1; cycle();
        set_req(1, 32'h1234, 32'h5678, 10'd42); cycle();
        set_req(0, '0, '0, '0);
        chk("restart_valid", 64'(mem_req_valid), 64'd1);
        chk("restart_k", 64'(mem_addr_k), 64'h1234);

        // randomized traffic against the model, with one reset partway through
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            if ($urandom_range(0, 19) == 0) sched_en = ~sched_en;
            set_req(1'($urandom_range(0, 1)), $urandom, $urandom, 10'($urandom_range(0, 1023)));
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_resp_valid = (m_out > 0) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 40) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_req_scheduler.md
Name: dram_req_scheduler

Overview:
- Sits between the Datapath DRAM request outputs (DRAM_valid, addr_k, addr_l) and the external memory request port.
- Buffers requests in a small FIFO and issues them with a valid/ready handshake.
- Limits in-flight requests against returned responses (DRAM_get) and raises a back-pressure stall to the pipeline before the FIFO can overflow.
- An enable/drain state machine lets the top level quiesce memory traffic between batches.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=4)
- MAX_OUT, 16, maximum outstanding issued-but-unanswered requests (<=255)
- TAG_W, 10, width of request tag (read_num)

Ports:
- Clk_32UI  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sched_en  in  1  1 = issue requests; falling edge starts a drain
- req_valid  in  1  request from Datapath (DRAM_valid)
- req_addr_k  in  32  k address
- req_addr_l  in  32  l address
- req_tag  in  TAG_W  read_num of the request
- bp_stall  out  1  back-pressure, ORed into the pipeline stall by the top level
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr_k  out  32  issued k address
- mem_addr_l  out  32  issued l address
- mem_req_tag  out  TAG_W  issued tag
- mem_resp_valid  in  1  response returned (DRAM_get), one per issued request
- outstanding  out  8  current in-flight count
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- drained  out  1  one-cycle pulse when a drain completes
- err_overflow  out  1  sticky: push while FIFO full
- err_underflow  out  1  sticky: response while outstanding==0

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- FIFO
  - Entry is {tag, addr_l, addr_k}.
  - Push when req_valid && !full; push is accepted in every state.
  - req_valid while full: request dropped, err_overflow set and held until reset.
  - Pop on mem_req_valid && mem_req_ready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and no overflow is flagged.
  - Read/write pointers wrap modulo DEPTH.
- bp_stall is registered.
  - Asserted the cycle after fifo_count_next >= DEPTH-2.
  - Deasserted the cycle after fifo_count_next < DEPTH-2.
  - This gives the pipeline 2 cycles of slack.
- Issue rules
  - mem_req_valid = (state==RUN || state==DRAIN) && !empty && outstanding < MAX_OUT.
  - mem_addr_k, mem_addr_l and mem_req_tag come directly from the FIFO head and stay stable while valid && !ready.
  - Once asserted, valid is not withdrawn until accepted, except on reset.
  - When the FIFO is empty, mem_* data outputs hold their last value.
- Outstanding counter (8 bits)
  - +1 on issue, -1 on mem_resp_valid.
  - Both in the same cycle: unchanged.
  - mem_resp_valid with outstanding==0: counter stays 0 and err_underflow is set (sticky).
- State machine
  - IDLE: no issue. Go to RUN when sched_en=1.
  - RUN: issue. Go to DRAIN when sched_en=0.
  - DRAIN: keep issuing until FIFO empty && outstanding==0 (next-state values), then go to IDLE and pulse drained for 1 cycle. If sched_en rises during DRAIN, return to RUN with no drained pulse.
- Latency: a request pushed into an empty FIFO in RUN, with credit available, presents mem_req_valid on the next cycle (1-cycle latency).
- Asynchronous reset mid-operation:
  - Clears FIFO, counters, errors and state immediately.
  - In-flight responses arriving after reset raise err_underflow.

Optional Feature:
- Macro: DRAM_SCHED_PERF_EN.
- With the macro defined, the block adds three 32-bit outputs:
  - perf_issued: count of accepted mem requests.
  - perf_bp_cycles: cycles with bp_stall=1.
  - perf_credit_cycles: cycles where the FIFO is non-empty but outstanding==MAX_OUT.
- All three counters reset to 0, saturate at 0xFFFFFFFF, and count only while state != IDLE.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- sched_en=1, mem_req_ready=1, single push of tag=5, addr_k=0x100, addr_l=0x200 -> next cycle mem_req_valid=1 carrying those values; outstanding=1; one mem_resp_valid -> outstanding=0.
- mem_req_ready=0, push 6 requests with DEPTH=8 -> bp_stall=1 from the cycle after the 6th push; push 3 more -> 9th dropped, err_overflow=1, fifo_count=8.
- MAX_OUT=16, ready=1, no responses, 20 pushes -> exactly 16 issued, mem_req_valid=0 with fifo_count=4; one response -> one more issue, outstanding back to 16.
- Same-cycle issue and response with outstanding=3 -> outstanding remains 3; response with outstanding=0 -> err_underflow=1, outstanding=0.
- 4 queued and 2 outstanding, drop sched_en -> all 4 issued, and drained pulses exactly 1 cycle after the final response; state IDLE with no further issue on later pushes.
- Assert reset_n=0 mid-burst with mem_req_valid=1 -> all outputs 0 immediately; after release, first push issues normally once sched_en=1.
